// File: rtl/ttl_serial_arbiter.sv
// Two-requester arbiter for a shared half-duplex UART: round-robin grant, TX forwarding,
// turnaround guard, counted RX reply with inter-byte timeout.
module ttl_serial_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 625,
    parameter int unsigned TIMEOUT_CYCLES = 72000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [15:0] tx_data,
    input  logic [1:0]  tx_valid,
    input  logic [1:0]  tx_last,
    output logic [1:0]  tx_ready,
    input  logic [15:0] rx_len,
    output logic [7:0]  rx_data,
    output logic [1:0]  rx_valid,
    output logic [1:0]  done,
    output logic [1:0]  timeout,
    output logic [7:0]  u_tx_data,
    output logic        u_tx_valid,
    input  logic        u_tx_ready,
    input  logic [7:0]  u_rx_data,
    input  logic        u_rx_valid,
    output logic        u_dir_tx
);

    typedef enum logic [2:0] {StIdle, StTx, StTxDrain, StGuard, StRx, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] cnt_q, cnt_d;
    logic        tflag_q, tflag_d;
    logic        abort_q, abort_d;
    logic        drain_first_q, drain_first_d;
    logic [1:0]  rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;

    logic g;
    logic winner;
    assign g = gnt_q[1];
    // On a tie the port that was not served last wins.
    assign winner = (req[0] && (!req[1] || last_q)) ? 1'b0 : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            gnt_q         <= 2'b00;
            last_q        <= 1'b1;
            len_q         <= 8'd0;
            count_q       <= 8'd0;
            cnt_q         <= 32'd0;
            tflag_q       <= 1'b0;
            abort_q       <= 1'b0;
            drain_first_q <= 1'b0;
            rx_valid_q    <= 2'b00;
            rx_data_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_q        <= last_d;
            len_q         <= len_d;
            count_q       <= count_d;
            cnt_q         <= cnt_d;
            tflag_q       <= tflag_d;
            abort_q       <= abort_d;
            drain_first_q <= drain_first_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        len_d         = len_q;
        count_d       = count_q;
        cnt_d         = cnt_q;
        tflag_d       = tflag_q;
        abort_d       = abort_q;
        drain_first_d = drain_first_q;
        rx_valid_d    = 2'b00;
        rx_data_d     = rx_data_q;

        // Bytes seen outside RX (own echo, line noise) never reach the requester.
        if (state_q == StRx && req[g] && u_rx_valid) begin
            rx_valid_d = gnt_q;
            rx_data_d  = u_rx_data;
            count_d    = count_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = 32'd0;
                if (req != 2'b00) begin
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    len_d   = winner ? rx_len[15:8] : rx_len[7:0];
                    count_d = 8'd0;
                    tflag_d = 1'b0;
                    abort_d = 1'b0;
                    state_d = StTx;
                end
            end
            StTx: begin
                if (!req[g]) begin
                    abort_d       = 1'b1;
                    drain_first_d = 1'b1;
                    state_d       = StTxDrain;
                end else if (tx_valid[g] && u_tx_ready && tx_last[g]) begin
                    drain_first_d = 1'b1;
                    state_d       = StTxDrain;
                end
            end
            StTxDrain: begin
                // The entry cycle is skipped so the accept of the last byte is not mistaken
                // for the UART having finished shifting it out.
                drain_first_d = 1'b0;
                if (!drain_first_q && u_tx_ready) begin
                    cnt_d = 32'd0;
                    if (abort_q) begin
                        gnt_d   = 2'b00;
                        state_d = StIdle;
                    end else begin
                        state_d = StGuard;
                    end
                end
            end
            StGuard: begin
                cnt_d = cnt_q + 32'd1;
                if (!req[g]) begin
                    gnt_d   = 2'b00;
                    state_d = StIdle;
                end else if (cnt_q == GUARD_CYCLES - 32'd1) begin
                    cnt_d   = 32'd0;
                    state_d = (len_q != 8'd0) ? StRx : StDone;
                end
            end
            StRx: begin
                cnt_d = u_rx_valid ? 32'd0 : cnt_q + 32'd1;
                if (!req[g]) begin
                    gnt_d   = 2'b00;
                    state_d = StIdle;
                end else if (count_q == len_q) begin
                    state_d = StDone;
                end else if (!u_rx_valid && (cnt_q + 32'd1 == TIMEOUT_CYCLES)) begin
                    tflag_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                gnt_d   = 2'b00;
                last_d  = g;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt        = gnt_q;
        rx_valid   = rx_valid_q;
        rx_data    = rx_data_q;
        tx_ready   = 2'b00;
        u_tx_valid = 1'b0;
        u_tx_data  = 8'd0;
        u_dir_tx   = 1'b0;
        done       = 2'b00;
        timeout    = 2'b00;
        unique case (state_q)
            StTx: begin
                u_dir_tx    = 1'b1;
                u_tx_valid  = tx_valid[g];
                u_tx_data   = g ? tx_data[15:8] : tx_data[7:0];
                tx_ready[g] = u_tx_ready;
            end
            StTxDrain: u_dir_tx = 1'b1;
            StDone: begin
                done    = gnt_q;
                timeout = tflag_q ? gnt_q : 2'b00;
            end
            default: ;
        endcase
    end

endmodule
